// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues instruction fetches and loads the IF/ID register; one branch delay slot.
// Latency: a word returned in the request cycle reaches IF/ID at the next edge; a skidded word moves in when stall_d drops.
// Backpressure: stall_d freezes PC and IF/ID; a word returned during a stall is parked in a one-entry skid and fetching pauses.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_d,
    input  logic [1:0]  pc_src,
    input  logic [31:0] npc_target,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        valid_d
);

    typedef enum logic {FETCH, HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, next_pc;
    logic [31:0] skid_instr, skid_pc;
    logic        pend;
    logic [31:0] pend_target;

    logic        take_mem, to_hold, from_hold, bubble, advance;
    logic        live_redirect;
    logic [31:0] live_target;

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign pc8_d     = pc_d + 32'd8;

    always_comb begin
        take_mem      = 1'b0;
        to_hold       = 1'b0;
        from_hold     = 1'b0;
        bubble        = 1'b0;
        state_nxt     = state;
        live_redirect = valid_d && !stall_d && (pc_src == 2'b01 || pc_src == 2'b10);
        live_target   = (pc_src == 2'b10) ? jr_target : npc_target;
        case (state)
            FETCH: begin
                take_mem = imem_rvalid && !stall_d;
                to_hold  = imem_rvalid && stall_d;
                bubble   = !imem_rvalid && !stall_d;
                if (to_hold) state_nxt = HOLD;
            end
            HOLD: begin
                from_hold = !stall_d;
                if (from_hold) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
        // The word entering D now is the delay slot, so a redirect only steers the fetch after it.
        advance = take_mem || from_hold;
        if (pend)
            next_pc = pend_target;
        else if (live_redirect)
            next_pc = live_target;
        else
            next_pc = pc + 32'(PC_STEP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr_d     <= 32'd0;
            pc_d        <= 32'd0;
            valid_d     <= 1'b0;
            skid_instr  <= 32'd0;
            skid_pc     <= 32'd0;
            pend        <= 1'b0;
            pend_target <= 32'd0;
        end else begin
            state <= state_nxt;
            if (take_mem) begin
                instr_d <= imem_rdata;
                pc_d    <= pc;
                valid_d <= 1'b1;
            end else if (from_hold) begin
                instr_d <= skid_instr;
                pc_d    <= skid_pc;
                valid_d <= 1'b1;
            end else if (bubble) begin
                valid_d <= 1'b0;
            end
            if (to_hold) begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc;
            end
            // Slot word not taken yet: remember where to go once it is.
            if (advance) begin
                pc   <= next_pc;
                pend <= 1'b0;
            end else if (live_redirect) begin
                pend        <= 1'b1;
                pend_target <= live_target;
            end
        end
    end

endmodule
